dpram_stream_reader: RTL and testbench

- Read-side controller for the dual-port acquisition RAM; the RAM write side is filled by the capture path.
- On a start command, reads a contiguous window (base address, length, wrapping) through the RAM read port (rd/raddr, rdata valid one cycle after rd).
- Emits the words as a valid/ready stream toward the USB/FT interface logic.
- Absorbs the RAM read latency and downstream backpressure with an internal prefetch FIFO, sustaining 1 word/cycle when the sink is always ready.

---
 rtl/dpram_stream_reader_pkg.sv | 21 ++
 rtl/dpram_stream_reader_fifo.sv | 123 ++++++++++++
 rtl/dpram_stream_reader.sv | 195 +++++++++++++++++++
 tb/tb_dpram_stream_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_stream_reader_pkg.sv
// dpram_stream_reader_pkg
//   Shared definitions for the acquisition-RAM stream reader.
//   - state_e        : controller states (IDLE / RUN / DRAIN)
//   - RAM_RD_LATENCY : cycles from ram_rd to valid ram_rdata
//   - cnt_width()    : width of the length / read / capture counters
package dpram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int RAM_RD_LATENCY = 1;

    // Counters must hold 0..2**addr_w inclusive, so one bit more than the address.
    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/dpram_stream_reader_fifo.sv
// sync_fifo_reg
//   Register-based synchronous FIFO with flush.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empties the FIFO (wins over push/pop)
//   push, push_data : write one entry
//   pop         : drop the head entry
//   head        : current head entry (meaningful while !empty)
//   count, empty: occupancy
module sync_fifo_reg #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_s, do_push_s, do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign empty  = (count_q == '0);
    assign full_s = (count_q == CNT_FULL);
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push && (!full_s || pop);
        do_pop_s  = pop && !empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    sync_fifo_reg_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push && !flush),
        .pop   (pop && !flush),
        .full  (full_s),
        .empty (empty)
    );

endmodule

// sync_fifo_reg_chk: overflow / underflow must never happen in this design.
module sync_fifo_reg_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic full,
    input logic empty
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop))
        else $error("sync_fifo_reg overflow");

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty))
        else $error("sync_fifo_reg underflow");
endmodule

// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader
//   Reads a wrapping window of the acquisition RAM and streams it out.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, base_addr, length, abort : command interface (sampled in IDLE)
//   busy, done          : status (done is a one-cycle pulse)
//   ram_rd, ram_raddr, ram_rdata    : RAM read port, data one cycle after rd
//   out_data, out_valid, out_ready, out_last : valid/ready output stream
module dpram_stream_reader
    import dpram_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    localparam int CNT_W      = cnt_width(ADDR_W);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [FIFO_CNT_W:0] DEPTH_C = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              inflight_q, inflight_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [FIFO_CNT_W-1:0] fifo_count_s;
    logic [FIFO_CNT_W:0]   occupancy_s;
    logic                  fifo_empty_s;
    logic [DATA_W:0]       fifo_head_s;
    logic                  rd_en_s, push_s, push_last_s, pop_s, flush_s;

    // Words already held or still coming back from the RAM; built only from
    // registers so out_ready has no combinational path to ram_rd.
    assign occupancy_s = {1'b0, fifo_count_s} + {{FIFO_CNT_W{1'b0}}, inflight_q};

    // Read issue: window not exhausted and room for the returning word.
    always_comb begin
        rd_en_s = 1'b0;
        if ((state_q == ST_RUN) && (rd_cnt_q != len_q) && (occupancy_s < DEPTH_C)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    assign push_s      = inflight_q;
    assign push_last_s = (wr_cnt_q == (len_q - CNT_W'(1)));
    assign out_valid   = !fifo_empty_s;
    assign pop_s       = out_valid && out_ready;
    assign flush_s     = abort && (state_q != ST_IDLE);
    assign out_data    = out_valid ? fifo_head_s[DATA_W-1:0] : '0;
    assign out_last    = out_valid && fifo_head_s[DATA_W];
    assign ram_rd      = rd_en_s;
    assign ram_raddr   = raddr_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Controller next-state: command capture, address/counters, completion.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        raddr_d    = raddr_q;
        inflight_d = rd_en_s;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_cnt_d   = push_s ? (wr_cnt_q + CNT_W'(1)) : wr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = length;
                    raddr_d  = base_addr;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    if (length != '0) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rd_en_s) begin
                    raddr_d  = raddr_q + ADDR_W'(1);
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    if ((rd_cnt_q + CNT_W'(1)) == len_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && fifo_head_s[DATA_W]) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // Abort drops everything, including the word still coming from the RAM.
        if (flush_s) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            inflight_d = 1'b0;
        end else begin
            inflight_d = rd_en_s;
        end
    end

    // Controller registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            raddr_q    <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            raddr_q    <= raddr_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    sync_fifo_reg #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_s),
        .push      (push_s),
        .push_data ({push_last_s, ram_rdata}),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

    dpram_stream_reader_chk #(.FIFO_DEPTH(FIFO_DEPTH)) u_chk ();

endmodule

// dpram_stream_reader_chk: configuration limits the read pipeline relies on.
module dpram_stream_reader_chk
    import dpram_stream_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    if (FIFO_DEPTH < 3) begin : g_depth_chk
        $error("dpram_stream_reader: FIFO_DEPTH must be >= 3");
    end
    if (RAM_RD_LATENCY != 1) begin : g_lat_chk
        $error("dpram_stream_reader: single in-flight stage assumes RAM latency 1");
    end
endmodule

// File: tb/tb_dpram_stream_reader.sv
module tb_dpram_stream_reader;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int FD = 4;
    localparam int RAM_WORDS = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, out_ready;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [DW-1:0] ram_rdata = '0;
    wire           busy, done, ram_rd, out_valid, out_last;
    wire  [AW-1:0] ram_raddr;
    wire  [DW-1:0] out_data;

    logic [DW-1:0] mem [RAM_WORDS];

    int vecs = 0;
    int errs = 0;

    // bench model: what must come out, and which addresses must be read
    logic [DW:0]   exp_q [$];
    logic [AW-1:0] addr_q [$];
    logic [DW-1:0] got_q [$];
    logic [AW-1:0] addr_log [$];
    int            outstanding = 0;
    bit            prev_stall = 1'b0;
    logic [DW:0]   prev_word = '0;
    bit            mon_en = 1'b0;

    dpram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .abort(abort), .busy(busy), .done(done),
        .ram_rd(ram_rd), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    // synchronous RAM read port, one cycle latency
    always @(posedge clk) if (ram_rd) ram_rdata <= mem[ram_raddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_model();
        exp_q.delete();
        addr_q.delete();
        outstanding = 0;
        prev_stall  = 1'b0;
    endtask

    task automatic load_model(input int b, input int len);
        flush_model();
        got_q.delete();
        addr_log.delete();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, mem[(b + i) % RAM_WORDS]});
            addr_q.push_back(AW'((b + i) % RAM_WORDS));
        end
    endtask

    function automatic logic ready_pat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        else return ((cyc - 1) % 3) == 0;
    endfunction

    // per-cycle compare of RAM reads and stream words against the model
    always @(negedge clk) begin
        if (mon_en && rst_n === 1'b1) begin
            if (ram_rd === 1'b1) begin
                if (addr_q.size() == 0) check("rd_extra", 32'd1, 32'd0);
                else check("rd_addr", 32'(ram_raddr), 32'(addr_q.pop_front()));
                check("rd_credit", (outstanding < FD) ? 32'd1 : 32'd0, 32'd1);
                addr_log.push_back(ram_raddr);
                outstanding++;
            end
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) check("out_extra", 32'd1, 32'd0);
                else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0][DW-1:0]));
                    check("out_last", 32'(out_last), 32'(exp_q[0][DW]));
                    if (prev_stall) check("hold", 32'({out_last, out_data}), 32'(prev_word));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got_q.push_back(out_data);
                        outstanding--;
                    end
                end
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    task automatic run_xfer(input int b, input int len, input int mode);
        int  cyc, done_cyc, last_hs, first_valid;
        bit  got_done;
        load_model(b, len);
        base_addr = AW'(b);
        length    = (AW + 1)'(len);
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1; got_done = 1'b0; done_cyc = -1; last_hs = -1; first_valid = -1;
        while (!got_done && cyc < 200) begin
            out_ready = ready_pat(mode, cyc);
            @(negedge clk);
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready && out_last) last_hs = cyc;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                check("busy_at_done", 32'(busy), 32'd0);
            end else begin
                check("busy", 32'(busy), (len > 0) ? 32'd1 : 32'd0);
            end
            tick();
            cyc++;
        end
        check("done_seen", 32'(got_done), 32'd1);
        if (len == 0) begin
            check("zero_done_cyc", 32'(done_cyc), 32'd1);
            check("zero_no_valid", 32'(first_valid), 32'hFFFF_FFFF);
        end else begin
            check("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
            if (mode == 0) begin
                check("first_valid_lat", 32'(first_valid), 32'd3);
                check("throughput", 32'(done_cyc), 32'(len + 3));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("words_left", 32'(exp_q.size()), 32'd0);
        check("reads_left", 32'(addr_q.size()), 32'd0);
        check("word_count", 32'(got_q.size()), 32'(len));
        tick();
    endtask

    initial begin
        for (int i = 0; i < RAM_WORDS; i++) mem[i] = 16'hA000 + 16'(i);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = '0; length = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd", 32'(ram_rd), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();

        // basic window
        run_xfer(2, 5, 0);
        check("basic_first", 32'(got_q[0]), 32'h0000_A002);
        check("basic_last", 32'(got_q[4]), 32'h0000_A006);

        // wrapping window 14,15,0,1
        run_xfer(14, 4, 0);
        check("wrap_a0", 32'(addr_log[0]), 32'd14);
        check("wrap_a1", 32'(addr_log[1]), 32'd15);
        check("wrap_a2", 32'(addr_log[2]), 32'd0);
        check("wrap_a3", 32'(addr_log[3]), 32'd1);
        check("wrap_d2", 32'(got_q[2]), 32'h0000_A000);

        // backpressure 1,0,0 pattern
        run_xfer(4, 8, 1);
        check("bp_d7", 32'(got_q[7]), 32'h0000_A00B);

        // zero length
        run_xfer(6, 0, 0);

        // full depth from an unaligned base: every address once
        run_xfer(7, 16, 0);
        begin
            logic [RAM_WORDS-1:0] seen;
            seen = '0;
            for (int i = 0; i < addr_log.size(); i++) seen[addr_log[i]] = 1'b1;
            check("full_all_addr", 32'(seen), 32'h0000_FFFF);
        end

        // abort in the 4th cycle of a length-10 transfer
        load_model(5, 10);
        base_addr = AW'(5); length = (AW + 1)'(10); start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        flush_model();
        @(negedge clk);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd", 32'(ram_rd), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        tick();
        run_xfer(0, 2, 0);
        check("post_abort_d0", 32'(got_q[0]), 32'h0000_A000);
        check("post_abort_d1", 32'(got_q[1]), 32'h0000_A001);

        // async reset during RUN
        load_model(1, 10);
        base_addr = AW'(1); length = (AW + 1)'(10); start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        flush_model();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd", 32'(ram_rd), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(out_valid), 32'd0);
            check("post_rst_rd", 32'(ram_rd), 32'd0);
            tick();
        end
        run_xfer(9, 3, 0);
        check("post_rst_d0", 32'(got_q[0]), 32'h0000_A009);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
